// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory arbiter: port tags, starvation limit,
// byte-mask width and the last-grant state encoding.
package dmem_pkg;

    localparam int MASK_W = 4;

    localparam logic TAG_C = 1'b0;
    localparam logic TAG_D = 1'b1;

    localparam logic [2:0] STARVE_MAX = 3'd7;

    typedef enum logic {
        LG_C = 1'b0,
        LG_D = 1'b1
    } last_grant_t;

endpackage

// File: rtl/dmem_arb_grant.sv
// Combinational tie-break between the CPU and DMA ports.
// Build option DMEM_ARB_RR_EN selects round-robin ties; otherwise CPU wins ties unless D is starved.
module dmem_arb_grant
    import dmem_pkg::*;
(
    input  logic c_valid,
    input  logic d_valid,
    input  logic last_grant,
    input  logic starve_hit,
    output logic grant_c,
    output logic grant_d
);

    logic tie_to_c;

`ifdef DMEM_ARB_RR_EN
    // Starvation state is kept upstream but deliberately does not steer ties here.
    assign tie_to_c = (last_grant == LG_D) | (starve_hit & 1'b0);
`else
    assign tie_to_c = ~starve_hit | (last_grant & 1'b0);
`endif

    assign grant_c = c_valid & (~d_valid | tie_to_c);
    assign grant_d = d_valid & ~grant_c;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port valid/ready arbiter in front of a single-ported synchronous dmem.
// Tie policy is set by the DMEM_ARB_RR_EN build option (see dmem_arb_grant).
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  c_valid,
    input  logic [DATA_W/8-1:0]   c_wmask,
    input  logic [ADDR_W-1:0]     c_addr,
    input  logic [DATA_W-1:0]     c_wdata,
    output logic                  c_ready,
    output logic                  c_rvalid,
    output logic [DATA_W-1:0]     c_rdata,
    output logic                  c_stall,

    input  logic                  d_valid,
    input  logic [DATA_W/8-1:0]   d_wmask,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_ready,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,

    output logic                  mem_en,
    output logic [DATA_W/8-1:0]   mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_din,
    input  logic [DATA_W-1:0]     mem_dout
);

    // Handshake: a request is accepted on a rising clk where valid & ready are
    // both high; ready is combinational from the grant and forced low in reset.

    last_grant_t       last_grant;
    logic [2:0]        starve_cnt;
    logic              starve_hit;
    logic              grant_c;
    logic              grant_d;
    logic              rd_accept;
    logic              rd_pend;
    logic              rd_tag;
    logic [DATA_W-1:0] c_hold;
    logic [DATA_W-1:0] d_hold;

    assign starve_hit = (starve_cnt == STARVE_MAX);

    dmem_arb_grant u_grant (
        .c_valid    (c_valid),
        .d_valid    (d_valid),
        .last_grant (last_grant),
        .starve_hit (starve_hit),
        .grant_c    (grant_c),
        .grant_d    (grant_d)
    );

    assign c_ready = grant_c & rst_n;
    assign d_ready = grant_d & rst_n;
    assign c_stall = c_valid & ~c_ready;

    always_comb begin
        mem_en   = 1'b0;
        mem_we   = '0;
        mem_addr = '0;
        mem_din  = '0;
        if (c_ready) begin
            mem_en   = 1'b1;
            mem_we   = c_wmask;
            mem_addr = c_addr;
            mem_din  = c_wdata;
        end else if (d_ready) begin
            mem_en   = 1'b1;
            mem_we   = d_wmask;
            mem_addr = d_addr;
            mem_din  = d_wdata;
        end
    end

    assign rd_accept = mem_en & (mem_we == '0);

    assign c_rvalid = rd_pend & (rd_tag == TAG_C);
    assign d_rvalid = rd_pend & (rd_tag == TAG_D);

    // Read data passes straight through in the response cycle, then holds.
    assign c_rdata = c_rvalid ? mem_dout : c_hold;
    assign d_rdata = d_rvalid ? mem_dout : d_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= LG_D;
            starve_cnt <= '0;
            rd_pend    <= 1'b0;
            rd_tag     <= TAG_C;
            c_hold     <= '0;
            d_hold     <= '0;
        end else begin
            if (c_ready) begin
                last_grant <= LG_C;
            end else if (d_ready) begin
                last_grant <= LG_D;
            end

            if (d_ready) begin
                starve_cnt <= '0;
            end else if (d_valid && !starve_hit) begin
                starve_cnt <= starve_cnt + 3'd1;
            end

            rd_pend <= rd_accept;
            if (rd_accept) begin
                rd_tag <= d_ready ? TAG_D : TAG_C;
            end

            if (c_rvalid) begin
                c_hold <= mem_dout;
            end
            if (d_rvalid) begin
                d_hold <= mem_dout;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a transaction-level model predicts grants
// and read data; a separate monitor checks responses as the DUT presents them.
module tb_dmem_arbiter;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;

    logic              clk;
    logic              rst_n;
    logic              c_valid, d_valid;
    logic [3:0]        c_wmask, d_wmask;
    logic [ADDR_W-1:0] c_addr, d_addr;
    logic [31:0]       c_wdata, d_wdata;
    logic              c_ready, d_ready, c_rvalid, d_rvalid, c_stall;
    logic [31:0]       c_rdata, d_rdata;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din, mem_dout;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_valid(c_valid), .c_wmask(c_wmask), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ready(c_ready), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_stall(c_stall),
        .d_valid(d_valid), .d_wmask(d_wmask), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // ---------------- clock / reset / cycle count ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- synchronous BRAM environment ----------------
    logic [31:0] bram [DEPTH];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we == 4'b0000) begin
                mem_dout <= bram[mem_addr[5:0]];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_we[b]) bram[mem_addr[5:0]][8*b +: 8] <= mem_din[8*b +: 8];
                end
            end
        end
    end

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_c_q[$];
    logic [31:0] exp_d_q[$];
    int          due_c_q[$];
    int          due_d_q[$];
    logic [31:0] last_c, last_d;

    // Reference model: memory image, last winner (0=C, 1=D), D denial streak.
    logic [31:0] ref_mem [DEPTH];
    int          m_last;
    int          m_starve;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_c_q.delete(); exp_d_q.delete();
        due_c_q.delete(); due_d_q.delete();
        last_c   = '0;
        last_d   = '0;
        m_last   = 1;
        m_starve = 0;
    endtask

    // ---------------- predictor: expected grant + memory effect ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            bit gc, gd, c_wins;
`ifdef DMEM_ARB_RR_EN
            c_wins = (m_last == 1);
`else
            c_wins = (m_starve < 7);
`endif
            gc = c_valid && (!d_valid || c_wins);
            gd = d_valid && !gc;
            check("c_ready", 32'(c_ready), 32'(gc));
            check("d_ready", 32'(d_ready), 32'(gd));
            check("c_stall", 32'(c_stall), 32'(c_valid && !gc));
            check("mem_en", 32'(mem_en), 32'(gc || gd));
            check("mem_we", 32'(mem_we), gc ? 32'(c_wmask) : gd ? 32'(d_wmask) : 32'h0);
            if (gc || gd) begin
                logic [3:0]  wm;
                logic [5:0]  a;
                logic [31:0] wd;
                wm = gc ? c_wmask : d_wmask;
                a  = gc ? c_addr[5:0] : d_addr[5:0];
                wd = gc ? c_wdata : d_wdata;
                check("mem_addr", 32'(mem_addr), 32'(gc ? c_addr : d_addr));
                if (wm != 4'b0000) begin
                    check("mem_din", mem_din, wd);
                    for (int b = 0; b < 4; b++) begin
                        if (wm[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
                    end
                end else if (gc) begin
                    exp_c_q.push_back(ref_mem[a]);
                    due_c_q.push_back(cyc + 1);
                end else begin
                    exp_d_q.push_back(ref_mem[a]);
                    due_d_q.push_back(cyc + 1);
                end
                m_last = gc ? 0 : 1;
            end
            if (gd)           m_starve = 0;
            else if (d_valid) m_starve = (m_starve < 7) ? m_starve + 1 : 7;
        end
    end

    // ---------------- monitor: responses and reset outputs ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_c_ready", 32'(c_ready), 32'h0);
            check("rst_d_ready", 32'(d_ready), 32'h0);
            check("rst_c_rvalid", 32'(c_rvalid), 32'h0);
            check("rst_d_rvalid", 32'(d_rvalid), 32'h0);
            check("rst_c_rdata", c_rdata, 32'h0);
            check("rst_d_rdata", d_rdata, 32'h0);
            check("rst_mem_en", 32'(mem_en), 32'h0);
        end else begin
            bit rv_c, rv_d;
            rv_c = (due_c_q.size() > 0) && (due_c_q[0] == cyc);
            rv_d = (due_d_q.size() > 0) && (due_d_q[0] == cyc);
            if (rv_c) begin
                last_c = exp_c_q.pop_front();
                void'(due_c_q.pop_front());
            end
            if (rv_d) begin
                last_d = exp_d_q.pop_front();
                void'(due_d_q.pop_front());
            end
            check("c_rvalid", 32'(c_rvalid), 32'(rv_c));
            check("d_rvalid", 32'(d_rvalid), 32'(rv_d));
            check("c_rdata", c_rdata, last_c);
            check("d_rdata", d_rdata, last_d);
        end
    end

    // ---------------- driver tasks ----------------
    bit c_acc, d_acc;

    task automatic tick();
        @(negedge clk);
        c_acc = c_valid && c_ready;
        d_acc = d_valid && d_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drive_c(input bit v, input logic [3:0] wm, input int a, input logic [31:0] wd);
        c_valid = v; c_wmask = wm; c_addr = ADDR_W'(a); c_wdata = wd;
    endtask

    task automatic drive_d(input bit v, input logic [3:0] wm, input int a, input logic [31:0] wd);
        d_valid = v; d_wmask = wm; d_addr = ADDR_W'(a); d_wdata = wd;
    endtask

    task automatic rand_req(input bit is_d);
        bit          v;
        logic [3:0]  wm;
        v  = ($urandom_range(0, 3) != 0);
        wm = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
        if (is_d) drive_d(v, wm, $urandom_range(0, DEPTH - 1), $urandom);
        else      drive_c(v, wm, $urandom_range(0, DEPTH - 1), $urandom);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        rst_n = 1'b0;
        drive_c(0, 4'b0, 0, '0);
        drive_d(0, 4'b0, 0, '0);
        for (int i = 0; i < DEPTH; i++) begin
            bram[i]    = $urandom;
            ref_mem[i] = bram[i];
        end
        bram[6'h10] = 32'hDEADBEEF; ref_mem[6'h10] = 32'hDEADBEEF;
        bram[6'h20] = 32'h11223344; ref_mem[6'h20] = 32'h11223344;
        model_reset();
        do_reset();

        // C read of a known word
        drive_c(1, 4'b0000, 'h010, '0);
        tick();
        drive_c(0, 4'b0000, 0, '0);
        tick();
        tick();
        check("read_deadbeef", c_rdata, 32'hDEADBEEF);

        // Byte-lane write then read-after-write on the next cycle
        drive_c(1, 4'b0100, 'h020, 32'h00AB0000);
        tick();
        drive_c(1, 4'b0000, 'h020, '0);
        tick();
        drive_c(0, 4'b0000, 0, '0);
        tick();
        check("raw_merge", c_rdata, 32'h11AB3344);

        // Both valid from the first cycle after reset: when does D first win?
        do_reset();
        drive_c(1, 4'b0000, 'h004, '0);
        drive_d(1, 4'b0000, 'h008, '0);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            n++;
            if (d_acc) break;
        end
`ifdef DMEM_ARB_RR_EN
        check("first_d_grant", 32'(n), 32'd2);
`else
        check("first_d_grant", 32'(n), 32'd8);
`endif
        // Keep both requesting: alternation / starvation recovery continues
        repeat (16) tick();
        drive_c(0, 4'b0, 0, '0);
        drive_d(0, 4'b0, 0, '0);
        tick();

        // Idle window
        repeat (10) tick();

        // D read accepted, then reset pulsed over the response edge
        drive_d(1, 4'b0000, 'h008, '0);
        tick();
        check("d_read_accepted", 32'(d_acc), 32'd1);
        rst_n = 1'b0;
        model_reset();
        drive_d(0, 4'b0, 0, '0);
        drive_c(1, 4'b0000, 'h010, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        drive_c(0, 4'b0, 0, '0);
        repeat (3) tick();

        // Randomized traffic with handshake-respecting requesters
        for (int i = 0; i < 400; i++) begin
            if (!c_valid || c_acc) rand_req(1'b0);
            if (!d_valid || d_acc) rand_req(1'b1);
            tick();
        end
        drive_c(0, 4'b0, 0, '0);
        drive_d(0, 4'b0, 0, '0);
        repeat (3) tick();

        if (exp_c_q.size() != 0 || exp_d_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d/%0d responses outstanding, expected 0/0",
                     exp_c_q.size(), exp_d_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
